// File: rtl/fft_pkg.sv
// fft_pkg: shared sample/lane types and delay clamp for the FFT pipeline stages.
package fft_pkg;
  localparam int FFT_DATA = 9;
  localparam int FFT_ARRAY = 16;
  typedef logic signed [FFT_DATA-1:0] sample_t;
  typedef sample_t lane_t [FFT_ARRAY];
  function automatic int clamp_delay(int sel, int max_depth);
    return sel < 1 ? 1 : sel > max_depth ? max_depth : sel;
  endfunction
endpackage

// File: rtl/fft_delay_line_if.sv
// fft_delay_line_if: control, input beat and tap output bundle of the delay line.
interface fft_delay_line_if #(
  parameter int DATA = 9,
  parameter int ARRAY = 16,
  parameter int MAX_DEPTH = 16,
  parameter int DW = $clog2(MAX_DEPTH + 1)
);
  logic en, flush, delay_ld, in_valid, out_valid;
  logic [DW-1:0] delay_sel, delay_q;
  logic signed [DATA-1:0] data_in_re [ARRAY];
  logic signed [DATA-1:0] data_in_im [ARRAY];
  logic signed [DATA-1:0] data_out_re [ARRAY];
  logic signed [DATA-1:0] data_out_im [ARRAY];
  modport master (
    output en, flush, delay_ld, delay_sel, in_valid, data_in_re, data_in_im,
    input out_valid, data_out_re, data_out_im, delay_q
  );
  modport slave (
    input en, flush, delay_ld, delay_sel, in_valid, data_in_re, data_in_im,
    output out_valid, data_out_re, data_out_im, delay_q
  );
endinterface

// File: rtl/fft_delay_line_tap_mux.sv
// dline_tap_mux: selects stage sel-1 of the line; DLINE_MASK_INVALID_EN zeroes data when invalid.
module dline_tap_mux #(
  parameter int DATA = 9,
  parameter int ARRAY = 16,
  parameter int MAX_DEPTH = 16,
  parameter int DW = $clog2(MAX_DEPTH + 1)
) (
  input  logic signed [DATA-1:0] s_re [MAX_DEPTH][ARRAY],
  input  logic signed [DATA-1:0] s_im [MAX_DEPTH][ARRAY],
  input  logic [MAX_DEPTH-1:0]   v,
  input  logic [DW-1:0]          sel,
  output logic signed [DATA-1:0] re [ARRAY],
  output logic signed [DATA-1:0] im [ARRAY],
  output logic                   valid
);
  localparam int AW = MAX_DEPTH > 1 ? $clog2(MAX_DEPTH) : 1;
  logic [AW-1:0] idx;
  logic keep;
  always_comb begin
    idx = AW'(sel - DW'(1));
    valid = v[idx];
`ifdef DLINE_MASK_INVALID_EN
    keep = valid;
`else
    keep = 1'b1;
`endif
    for (int j = 0; j < ARRAY; j++) begin
      re[j] = keep ? s_re[idx][j] : '0;
      im[j] = keep ? s_im[idx][j] : '0;
    end
  end
endmodule

// File: rtl/fft_delay_line.sv
// fft_delay_line: programmable-depth multi-lane complex delay line with stall, flush and valid tracking.
// Optional macro DLINE_MASK_INVALID_EN: zero data_out on all lanes while out_valid is low.
module fft_delay_line
  import fft_pkg::*;
#(
  parameter int DATA = FFT_DATA,
  parameter int ARRAY = FFT_ARRAY,
  parameter int MAX_DEPTH = 16,
  parameter int DEF_DELAY = 16,
  parameter int DW = $clog2(MAX_DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  fft_delay_line_if.slave dl
);
  logic signed [DATA-1:0] s_re_q [MAX_DEPTH][ARRAY];
  logic signed [DATA-1:0] s_re_d [MAX_DEPTH][ARRAY];
  logic signed [DATA-1:0] s_im_q [MAX_DEPTH][ARRAY];
  logic signed [DATA-1:0] s_im_d [MAX_DEPTH][ARRAY];
  logic [MAX_DEPTH-1:0] v_q, v_d;
  logic [DW-1:0] dly_q, dly_d;
  logic shift;
  // A delay load or flush swallows the cycle: no shift, input beat dropped.
  always_comb begin
    shift = dl.en && !dl.delay_ld && !dl.flush;
    dly_d = dl.delay_ld ? DW'(clamp_delay(int'(dl.delay_sel), MAX_DEPTH)) : dly_q;
    v_d = (dl.delay_ld || dl.flush) ? '0 : v_q;
    s_re_d = s_re_q;
    s_im_d = s_im_q;
    if (shift) begin
      v_d[0] = dl.in_valid;
      s_re_d[0] = dl.data_in_re;
      s_im_d[0] = dl.data_in_im;
      for (int k = 1; k < MAX_DEPTH; k++) begin
        v_d[k] = v_q[k-1];
        s_re_d[k] = s_re_q[k-1];
        s_im_d[k] = s_im_q[k-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_re_q <= '{default: '0};
      s_im_q <= '{default: '0};
      v_q <= '0;
      dly_q <= DW'(DEF_DELAY);
    end else begin
      s_re_q <= s_re_d;
      s_im_q <= s_im_d;
      v_q <= v_d;
      dly_q <= dly_d;
    end
  end
  assign dl.delay_q = dly_q;
  dline_tap_mux #(.DATA(DATA), .ARRAY(ARRAY), .MAX_DEPTH(MAX_DEPTH), .DW(DW)) u_tap (
    .s_re(s_re_q),
    .s_im(s_im_q),
    .v(v_q),
    .sel(dly_q),
    .re(dl.data_out_re),
    .im(dl.data_out_im),
    .valid(dl.out_valid)
  );
endmodule

// File: tb/tb_fft_delay_line.sv
// tb_fft_delay_line: directed table-driven bench for fft_delay_line.
module tb_fft_delay_line;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fft_delay_line_if dl ();
  fft_delay_line u_dut (.clk(clk), .rst(rst), .dl(dl));
`ifdef DLINE_MASK_INVALID_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif
  typedef struct {
    int r, en, fl, ld, iv, sel, val;
    int ov, re, dq;
  } vec_t;
  vec_t vecs[$];
  int tests = 0;
  int fails = 0;
  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(int r, int en, int fl, int ld, int iv, int sel, int val);
    rst = (r != 0);
    dl.en = (en != 0);
    dl.flush = (fl != 0);
    dl.delay_ld = (ld != 0);
    dl.in_valid = (iv != 0);
    dl.delay_sel = 5'(sel);
    for (int j = 0; j < 16; j++) begin
      dl.data_in_re[j] = 9'(val);
      dl.data_in_im[j] = 9'(-val);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int exp_data(int ov, int raw);
    return (MASK && ov == 0) ? 0 : raw;
  endfunction
  initial begin
    // r en fl ld iv sel val | ov re dq
    vecs.push_back(vec_t'{0, 1, 0, 1, 1, 4, 99, 0, 17, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 1, 0, 10, 0, 18, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 1, 0, 11, 0, 19, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 20, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 1, 10, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 1, 11, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 0, 4});
    vecs.push_back(vec_t'{0, 1, 0, 1, 1, 0, 55, 0, 0, 1});
    vecs.push_back(vec_t'{0, 1, 0, 1, 1, 31, 55, 0, 11, 16});
    vecs.push_back(vec_t'{0, 1, 0, 1, 1, 3, 55, 0, 0, 3});
    vecs.push_back(vec_t'{0, 1, 0, 0, 1, 0, 42, 0, 0, 3});
    for (int i = 0; i < 5; i++) vecs.push_back(vec_t'{0, 0, 0, 0, 1, 0, 77, 0, 0, 3});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 0, 3});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 1, 42, 3});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 42, 3});
    vecs.push_back(vec_t'{0, 1, 0, 1, 0, 4, 0, 0, 0, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 1, 0, 1, 0, 42, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 1, 0, 2, 0, 0, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 1, 0, 3, 0, 0, 4});
    vecs.push_back(vec_t'{0, 1, 1, 0, 1, 0, 4, 0, 0, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 1, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 2, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 3, 4});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 0, 4});
    vecs.push_back(vec_t'{0, 1, 1, 1, 1, 2, 9, 0, 0, 2});
    vecs.push_back(vec_t'{1, 1, 1, 1, 1, 5, 9, 0, 0, 16});
    drive(1, 0, 1, 1, 0, 3, 0);
    tick;
    tick;
    chk("reset out_valid", int'(dl.out_valid), 0);
    chk("reset delay_q", int'(dl.delay_q), 16);
    for (int j = 0; j < 16; j++) begin
      chk("reset re", int'(dl.data_out_re[j]), 0);
      chk("reset im", int'(dl.data_out_im[j]), 0);
    end
    for (int i = 1; i <= 20; i++) begin
      drive(0, 1, 0, 0, 1, 0, i);
      tick;
      chk("ramp out_valid", int'(dl.out_valid), i >= 16 ? 1 : 0);
      chk("ramp re0", int'(dl.data_out_re[0]), i >= 16 ? i - 15 : 0);
      chk("ramp im15", int'(dl.data_out_im[15]), i >= 16 ? 15 - i : 0);
    end
    foreach (vecs[n]) begin
      drive(vecs[n].r, vecs[n].en, vecs[n].fl, vecs[n].ld, vecs[n].iv, vecs[n].sel, vecs[n].val);
      tick;
      chk($sformatf("vec%0d out_valid", n), int'(dl.out_valid), vecs[n].ov);
      chk($sformatf("vec%0d re0", n), int'(dl.data_out_re[0]), exp_data(vecs[n].ov, vecs[n].re));
      chk($sformatf("vec%0d delay_q", n), int'(dl.delay_q), vecs[n].dq);
    end
    drive(0, 1, 0, 1, 0, 2, 0);
    tick;
    drive(0, 1, 0, 0, 1, 0, 0);
    for (int j = 0; j < 16; j++) begin
      dl.data_in_re[j] = 9'(-256 + j);
      dl.data_in_im[j] = 9'(255 - j);
    end
    tick;
    drive(0, 1, 0, 0, 0, 0, 0);
    tick;
    chk("lanes out_valid", int'(dl.out_valid), 1);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("lane%0d re", j), int'(dl.data_out_re[j]), -256 + j);
      chk($sformatf("lane%0d im", j), int'(dl.data_out_im[j]), 255 - j);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
